// File: rtl/ysyx_24100029_bus_pkg.sv
// Shared types for the bus master: bus opcodes, access sizes and FSM states.
package ysyx_24100029_bus_pkg;

  typedef enum logic [1:0] {
    OpIdle  = 2'd0,
    OpRead  = 2'd1,
    OpWrite = 2'd2
  } opcode_e;

  typedef enum logic [1:0] {
    SizeByte    = 2'd0,
    SizeHalf    = 2'd1,
    SizeWord    = 2'd2,
    SizeIllegal = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBus  = 2'd1,
    StResp = 2'd2
  } state_e;

endpackage

// File: rtl/ysyx_24100029_lane_align.sv
// Byte-lane helper: store strobe/lane generation, alignment check and load extraction.
// Purely combinational; the store side and the load side have independent inputs.
module ysyx_24100029_lane_align
  import ysyx_24100029_bus_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  size_e       size,
  input  logic [31:0] store_data,
  input  logic [1:0]  load_off,
  input  size_e       load_size,
  input  logic        load_unsigned,
  input  logic [31:0] bus_rdata,
  output logic        aligned,
  output logic [3:0]  strb,
  output logic [31:0] store_lanes,
  output logic [31:0] load_data
);

  logic [31:0] repl;
  logic [31:0] shifted;

  // Store side: strobe, legality and lane replication masked by the strobe.
  always_comb begin
    aligned = 1'b1;
    strb    = 4'b0000;
    repl    = 32'd0;
    unique case (size)
      SizeByte: begin
        strb = 4'b0001 << addr_lo;
        repl = {4{store_data[7:0]}};
      end
      SizeHalf: begin
        strb    = 4'b0011 << addr_lo;
        repl    = {2{store_data[15:0]}};
        aligned = ~addr_lo[0];
      end
      SizeWord: begin
        strb    = 4'b1111;
        repl    = store_data;
        aligned = (addr_lo == 2'b00);
      end
      default: aligned = 1'b0;
    endcase
    for (int i = 0; i < 4; i++) begin
      store_lanes[8*i +: 8] = strb[i] ? repl[8*i +: 8] : 8'h00;
    end
  end

  // Load side: shift the addressed lane down, then sign- or zero-extend.
  always_comb begin
    shifted = bus_rdata >> {load_off, 3'b000};
    unique case (load_size)
      SizeByte: load_data = load_unsigned ? {24'd0, shifted[7:0]}
                                          : {{24{shifted[7]}}, shifted[7:0]};
      SizeHalf: load_data = load_unsigned ? {16'd0, shifted[15:0]}
                                          : {{16{shifted[15]}}, shifted[15:0]};
      SizeWord: load_data = bus_rdata;
      default:  load_data = 32'd0;
    endcase
  end

endmodule

// File: rtl/ysyx_24100029_bus_master.sv
// CPU-to-bus master: accepts one load/store, runs it on the bus, returns a response.
// Optional bus timeout enabled by defining YSYX_24100029_BUS_TIMEOUT_EN.
module ysyx_24100029_bus_master
  import ysyx_24100029_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] addr,
  output logic [1:0]  opcode,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  input  logic [31:0] rdata,
  input  logic        resp
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES out of range 1..65535");
  end

  state_e      state_q;
  opcode_e     opcode_q;
  logic [31:0] addr_q, wdata_q, rsp_rdata_q;
  logic [3:0]  wstrb_q;
  logic        rsp_valid_q, rsp_err_q;
  logic [1:0]  off_q;
  size_e       size_q;
  logic        uns_q, we_q, first_q;
`ifdef YSYX_24100029_BUS_TIMEOUT_EN
  logic [15:0] cnt_q;
`endif

  logic        aligned;
  logic [3:0]  strb;
  logic [31:0] store_lanes, load_data;

  ysyx_24100029_lane_align u_lane_align (
    .addr_lo      (req_addr[1:0]),
    .size         (size_e'(req_size)),
    .store_data   (req_wdata),
    .load_off     (off_q),
    .load_size    (size_q),
    .load_unsigned(uns_q),
    .bus_rdata    (rdata),
    .aligned      (aligned),
    .strb         (strb),
    .store_lanes  (store_lanes),
    .load_data    (load_data)
  );

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign addr      = addr_q;
  assign opcode    = opcode_q;
  assign wdata     = wdata_q;
  assign wstrb     = wstrb_q;

  // Transaction FSM; every bus and response output is registered here.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      opcode_q    <= OpIdle;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      wstrb_q     <= 4'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
      off_q       <= 2'd0;
      size_q      <= SizeByte;
      uns_q       <= 1'b0;
      we_q        <= 1'b0;
      first_q     <= 1'b0;
`ifdef YSYX_24100029_BUS_TIMEOUT_EN
      cnt_q       <= 16'd0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            off_q  <= req_addr[1:0];
            size_q <= size_e'(req_size);
            uns_q  <= req_unsigned;
            we_q   <= req_we;
            if (aligned) begin
              state_q  <= StBus;
              addr_q   <= {req_addr[31:2], 2'b00};
              opcode_q <= req_we ? OpWrite : OpRead;
              wdata_q  <= req_we ? store_lanes : 32'd0;
              wstrb_q  <= req_we ? strb : 4'd0;
              first_q  <= 1'b1;
`ifdef YSYX_24100029_BUS_TIMEOUT_EN
              cnt_q    <= 16'd0;
`endif
            end else begin
              // Bad requests never reach the bus.
              state_q     <= StResp;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= 32'd0;
            end
          end
        end
        StBus: begin
          first_q <= 1'b0;
          // resp in the first cycle may belong to a previous access.
          if (resp && !first_q) begin
            state_q     <= StResp;
            opcode_q    <= OpIdle;
            wdata_q     <= 32'd0;
            wstrb_q     <= 4'd0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= we_q ? 32'd0 : load_data;
          end
`ifdef YSYX_24100029_BUS_TIMEOUT_EN
          else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
            state_q     <= StResp;
            opcode_q    <= OpIdle;
            wdata_q     <= 32'd0;
            wstrb_q     <= 4'd0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= 32'd0;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
`endif
        end
        StResp: begin
          if (rsp_ready) begin
            state_q     <= StIdle;
            rsp_valid_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_24100029_bus_master.sv
// Directed self-checking bench for ysyx_24100029_bus_master.
module tb_ysyx_24100029_bus_master;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata, addr, wdata, rdata;
  logic [1:0]  opcode;
  logic [3:0]  wstrb;
  logic        resp;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  ysyx_24100029_bus_master #(.TIMEOUT_CYCLES(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_size    (req_size),
    .req_unsigned(req_unsigned),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .addr        (addr),
    .opcode      (opcode),
    .wdata       (wdata),
    .wstrb       (wstrb),
    .rdata       (rdata),
    .resp        (resp)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Present a request for one edge; afterwards the DUT is in its first BUS cycle.
  task automatic issue(input logic we, input logic [31:0] a, input logic [1:0] sz,
                       input logic uns, input logic [31:0] wd);
    req_valid = 1'b1; req_we = we; req_addr = a; req_size = sz;
    req_unsigned = uns; req_wdata = wd;
    step();
    req_valid = 1'b0;
  endtask

  // Raise resp in BUS cycle `cyc` (1-based) with data rd; afterwards the DUT is in RESP.
  task automatic respond(input int cyc, input logic [31:0] rd);
    for (int i = 1; i < cyc; i++) step();
    resp = 1'b1; rdata = rd;
    step();
    resp = 1'b0; rdata = 32'd0;
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_size = 2'd0;
    req_unsigned = 1'b0; req_wdata = 32'd0; rsp_ready = 1'b0; rdata = 32'd0; resp = 1'b0;
    step(); step();
    reset = 1'b0;

    check_eq("rst_opcode", 32'(opcode), 32'd0);
    check_eq("rst_addr", addr, 32'd0);
    check_eq("rst_wdata", wdata, 32'd0);
    check_eq("rst_wstrb", 32'(wstrb), 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rsp_rdata", rsp_rdata, 32'd0);
    check_eq("rst_rsp_err", 32'(rsp_err), 32'd0);
    check_eq("rst_req_ready", 32'(req_ready), 32'd1);

    // Word load, resp on BUS cycle 2.
    issue(1'b0, 32'h0200_BFF8, 2'd2, 1'b0, 32'd0);
    check_eq("wl_opcode_c1", 32'(opcode), 32'd1);
    check_eq("wl_addr", addr, 32'h0200_BFF8);
    check_eq("wl_wstrb", 32'(wstrb), 32'd0);
    check_eq("wl_req_ready", 32'(req_ready), 32'd0);
    check_eq("wl_rsp_valid_c1", 32'(rsp_valid), 32'd0);
    step();
    check_eq("wl_opcode_c2", 32'(opcode), 32'd1);
    resp = 1'b1; rdata = 32'h1234_5678;
    step();
    resp = 1'b0; rdata = 32'd0;
    check_eq("wl_opcode_done", 32'(opcode), 32'd0);
    check_eq("wl_rsp_valid", 32'(rsp_valid), 32'd1);
    check_eq("wl_rsp_rdata", rsp_rdata, 32'h1234_5678);
    check_eq("wl_rsp_err", 32'(rsp_err), 32'd0);
    consume();
    check_eq("wl_idle_valid", 32'(rsp_valid), 32'd0);
    check_eq("wl_idle_ready", 32'(req_ready), 32'd1);

    // Byte store to the top lane.
    issue(1'b1, 32'h8000_0003, 2'd0, 1'b0, 32'h0000_00A5);
    check_eq("bs_wstrb", 32'(wstrb), 32'h8);
    check_eq("bs_wdata_hi", 32'(wdata[31:24]), 32'hA5);
    check_eq("bs_opcode", 32'(opcode), 32'd2);
    check_eq("bs_addr", addr, 32'h8000_0000);
    respond(2, 32'hFFFF_FFFF);
    check_eq("bs_rsp_rdata", rsp_rdata, 32'd0);
    check_eq("bs_rsp_err", 32'(rsp_err), 32'd0);
    consume();

    // Half store to the upper half-word.
    issue(1'b1, 32'h8000_0002, 2'd1, 1'b0, 32'h0000_BEEF);
    check_eq("hs_wstrb", 32'(wstrb), 32'hC);
    check_eq("hs_wdata_hi", 32'(wdata[31:16]), 32'hBEEF);
    respond(2, 32'd0);
    consume();

    // Signed and unsigned half loads from the upper half.
    issue(1'b0, 32'h8000_0002, 2'd1, 1'b0, 32'd0);
    respond(2, 32'h8001_0000);
    check_eq("hl_signed", rsp_rdata, 32'hFFFF_8001);
    consume();
    issue(1'b0, 32'h8000_0002, 2'd1, 1'b1, 32'd0);
    respond(2, 32'h8001_0000);
    check_eq("hl_unsigned", rsp_rdata, 32'h0000_8001);
    consume();

    // Signed byte load from lane 1.
    issue(1'b0, 32'h8000_0001, 2'd0, 1'b0, 32'd0);
    respond(2, 32'h0000_8000);
    check_eq("bl_signed", rsp_rdata, 32'hFFFF_FF80);
    consume();

    // Misaligned word: no bus activity, error response one cycle after acceptance.
    issue(1'b0, 32'h8000_0002, 2'd2, 1'b0, 32'd0);
    check_eq("mis_opcode", 32'(opcode), 32'd0);
    check_eq("mis_rsp_valid", 32'(rsp_valid), 32'd1);
    check_eq("mis_rsp_err", 32'(rsp_err), 32'd1);
    check_eq("mis_rsp_rdata", rsp_rdata, 32'd0);
    consume();

    // Illegal size at an aligned address.
    issue(1'b0, 32'h8000_0000, 2'd3, 1'b0, 32'd0);
    check_eq("ill_opcode", 32'(opcode), 32'd0);
    check_eq("ill_rsp_err", 32'(rsp_err), 32'd1);
    consume();

    // Stale resp in the first BUS cycle must be ignored.
    issue(1'b0, 32'h0000_0100, 2'd2, 1'b0, 32'd0);
    resp = 1'b1; rdata = 32'hDEAD_BEEF;
    step();
    check_eq("stale_opcode", 32'(opcode), 32'd1);
    check_eq("stale_rsp_valid", 32'(rsp_valid), 32'd0);
    rdata = 32'hCAFE_F00D;
    step();
    resp = 1'b0; rdata = 32'd0;
    check_eq("stale_rsp_rdata", rsp_rdata, 32'hCAFE_F00D);

    // No acceptance in the same cycle as rsp_ready.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0200; req_size = 2'd2;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check_eq("turn_opcode", 32'(opcode), 32'd0);
    check_eq("turn_ready", 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    check_eq("turn_accept", 32'(opcode), 32'd1);
    respond(2, 32'h0000_0042);
    consume();

    // Reset in BUS abandons the access.
    issue(1'b0, 32'h0000_0300, 2'd2, 1'b0, 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("rbus_opcode", 32'(opcode), 32'd0);
    check_eq("rbus_rsp_valid", 32'(rsp_valid), 32'd0);
    resp = 1'b1; rdata = 32'h7777_7777;
    step(); step();
    resp = 1'b0; rdata = 32'd0;
    check_eq("rbus_no_rsp", 32'(rsp_valid), 32'd0);
    check_eq("rbus_ready", 32'(req_ready), 32'd1);

    // Response held stable while rsp_ready stays low.
    issue(1'b0, 32'h0000_0400, 2'd2, 1'b0, 32'd0);
    respond(2, 32'h1122_3344);
    for (int i = 0; i < 5; i++) begin
      check_eq("hold_valid", 32'(rsp_valid), 32'd1);
      check_eq("hold_rdata", rsp_rdata, 32'h1122_3344);
      check_eq("hold_err", 32'(rsp_err), 32'd0);
      resp = 1'b1; rdata = 32'h9999_0000 + 32'(i);
      step();
    end
    resp = 1'b0; rdata = 32'd0;
    consume();
    check_eq("hold_released", 32'(rsp_valid), 32'd0);

`ifdef YSYX_24100029_BUS_TIMEOUT_EN
    // Timeout after 4 BUS cycles.
    issue(1'b0, 32'h0000_0500, 2'd2, 1'b0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      check_eq("to_opcode", 32'(opcode), 32'd1);
      step();
    end
    check_eq("to_opcode_done", 32'(opcode), 32'd0);
    check_eq("to_rsp_valid", 32'(rsp_valid), 32'd1);
    check_eq("to_rsp_err", 32'(rsp_err), 32'd1);
    check_eq("to_rsp_rdata", rsp_rdata, 32'd0);
    consume();
    // resp on the timeout cycle wins.
    issue(1'b0, 32'h0000_0600, 2'd2, 1'b0, 32'd0);
    respond(4, 32'h5A5A_5A5A);
    check_eq("to_race_err", 32'(rsp_err), 32'd0);
    check_eq("to_race_rdata", rsp_rdata, 32'h5A5A_5A5A);
    consume();
`else
    // Without the timeout the master waits indefinitely.
    issue(1'b0, 32'h0000_0500, 2'd2, 1'b0, 32'd0);
    for (int i = 0; i < 20; i++) step();
    check_eq("wait_opcode", 32'(opcode), 32'd1);
    check_eq("wait_rsp_valid", 32'(rsp_valid), 32'd0);
    respond(1, 32'h5A5A_5A5A);
    check_eq("wait_rsp_err", 32'(rsp_err), 32'd0);
    check_eq("wait_rsp_rdata", rsp_rdata, 32'h5A5A_5A5A);
    consume();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
